dmem_responder: RTL and testbench

- Memory-side responder for the RV32 core's load/store port; the other end of the core's data-memory access interface.
- Accepts one request at a time over a valid/ready handshake and applies a fixed, programmable wait-state latency.
- Performs RV32 byte, half and word stores and loads (little-endian, sign/zero extension) on internal word storage.
- Returns the result over a response handshake. Used as the data memory for the multi-cycle/stall-capable core variant and its testbenches.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/lsu_align.sv | 64 ++++++
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions: funct3 codes, data width and the
// responder FSM state type.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational RV32 load/store lane steering: byte enables, replicated
// store lanes, load extraction with sign/zero extension, error flags.
module lsu_align
   import riscv_pkg::*;
(
   input  logic            we,
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rword,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wlanes,
   output logic [XLEN-1:0] rdata,
   output logic            misalign,
   output logic            illegal
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = rword[{addr_lo, 3'b000} +: 8];
   assign half_v = addr_lo[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      be       = '0;
      wlanes   = '0;
      rdata    = '0;
      misalign = 1'b0;
      illegal  = 1'b0;
      case (funct3)
         F3_B: begin
            be     = 4'b0001 << addr_lo;
            wlanes = {4{wdata[7:0]}};
            rdata  = {{24{byte_v[7]}}, byte_v};
         end
         F3_H: begin
            misalign = addr_lo[0];
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            wlanes   = {2{wdata[15:0]}};
            rdata    = {{16{half_v[15]}}, half_v};
         end
         F3_W: begin
            misalign = |addr_lo;
            be       = 4'b1111;
            wlanes   = wdata;
            rdata    = rword;
         end
         F3_BU: begin
            illegal = we;
            rdata   = {24'h0, byte_v};
         end
         F3_HU: begin
            illegal  = we;
            misalign = addr_lo[0];
            rdata    = {16'h0, half_v};
         end
         default: illegal = 1'b1;
      endcase
      // Enables only ever qualify a legal store; loads and errors see no lanes.
      if (!we || misalign || illegal) be = '0;
      if (misalign || illegal) rdata = '0;
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait-state latency,
// RV32 byte/half/word access on internal word storage.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int    ADDR_W      = 32,
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic accept, commit, wr_en;

  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [XLEN-1:0]   cap_wdata;
  logic [2:0]        cap_f3;

  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [XLEN-1:0]   op_wdata;
  logic [2:0]        op_f3;
  logic [ADDR_W-3:0] op_idx;
  logic [IDX_W-1:0]  mem_idx;

  logic [3:0]      be;
  logic [XLEN-1:0] wlanes, ld_data;
  logic            misalign, illegal, oor, err;

  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic [XLEN-1:0] mem [DEPTH];

  // With zero wait states the commit happens on the accept edge itself, so
  // the operation is taken straight from the request port while idle.
  assign op_we    = (state == IDLE) ? req_we     : cap_we;
  assign op_addr  = (state == IDLE) ? req_addr   : cap_addr;
  assign op_wdata = (state == IDLE) ? req_wdata  : cap_wdata;
  assign op_f3    = (state == IDLE) ? req_funct3 : cap_f3;

  assign op_idx  = op_addr[ADDR_W-1:2];
  assign mem_idx = op_idx[IDX_W-1:0];
  assign oor     = (op_idx >= DEPTH_IDX);
  assign err     = misalign | illegal | oor;

  lsu_align u_align (
    .we       (op_we),
    .funct3   (op_f3),
    .addr_lo  (op_addr[1:0]),
    .wdata    (op_wdata),
    .rword    (mem[mem_idx]),
    .be       (be),
    .wlanes   (wlanes),
    .rdata    (ld_data),
    .misalign (misalign),
    .illegal  (illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
            commit   = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = RESP;
          commit   = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_f3    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_f3    <= req_funct3;
        cnt       <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit) begin
        err_q   <= err;
        rdata_q <= (op_we || err) ? '0 : ld_data;
      end
    end
  end

  // Storage has no reset; rst gates the write so a held reset never commits.
  assign wr_en = commit && op_we && !err && !rst;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[mem_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: two instances
// (2 and 0 wait states) checked against a word-array reference model.
module tb_dmem_responder;
   import riscv_pkg::*;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic        req_we;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_funct3;
   logic [31:0] rsp_rdata [2];

   int total = 0;
   int bad   = 0;
   int wc [2] = '{2, 0};
   logic [31:0] mdl [2][DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(2), .INIT_FILE("")) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   dmem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: sizes, legality and little-endian lanes from plain arithmetic.
   task automatic model(input int s, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er);
      int unsigned size, sh;
      logic [31:0] m, w, v;
      bit legal, sgn;
      rd = '0;
      er = 1'b0;
      if (we) legal = (f3 <= 3'd2);
      else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      size = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
      if (!legal || (a % size) != 0 || (a / 4) >= DEPTH) begin
         er = 1'b1;
         return;
      end
      sh  = 8 * (a % 4);
      m   = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      sgn = (f3 < 3'd4);
      w   = mdl[s][a / 4];
      if (we) begin
         mdl[s][a / 4] = (w & ~(m << sh)) | ((d & m) << sh);
      end else begin
         v = (w >> sh) & m;
         if (sgn && size < 4 && v[8*size-1]) v = v | ~m;
         rd = v;
      end
   endtask

   task automatic op(input int s, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] f3, input int hold,
                     output logic [31:0] rd, output logic er);
      logic [31:0] erd;
      logic eer;
      int lat;
      model(s, we, a, d, f3, erd, eer);
      @(negedge clk);
      chk("idle_ready", req_ready[s], 1);
      req_we = we; req_addr = a; req_wdata = d; req_funct3 = f3;
      req_valid[s] = 1'b1;
      rsp_ready[s] = (hold == 0);
      @(posedge clk); #1;
      req_valid[s] = 1'b0;
      lat = 1;
      while (!rsp_valid[s] && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, wc[s] + 1);
      rd = rsp_rdata[s];
      er = rsp_err[s];
      if (!rsp_valid[s]) return;
      chk("rdata", rd, erd);
      chk("err", er, eer);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         req_valid[s] = (i == 1 || i == 2);
         req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'hBAD0_BAD0; req_funct3 = F3_W;
         @(posedge clk); #1;
         chk("bp_valid", rsp_valid[s], 1);
         chk("bp_rdata", rsp_rdata[s], rd);
         chk("bp_err", rsp_err[s], er);
         chk("bp_ready", req_ready[s], 0);
      end
      @(negedge clk);
      req_valid[s] = 1'b0;
      rsp_ready[s] = 1'b1;
      @(posedge clk); #1;
      chk("hs_valid", rsp_valid[s], 0);
      chk("hs_ready", req_ready[s], 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, a;
      logic er;
      int s, hold;
      rst = 1'b1; req_valid = '0; rsp_ready = '0;
      req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_req_ready", req_ready[k], 1);
         chk("rst_rsp_valid", rsp_valid[k], 0);
         chk("rst_rsp_rdata", rsp_rdata[k], 0);
         chk("rst_rsp_err", rsp_err[k], 0);
      end
      #20;
      @(negedge clk); rst = 1'b0;

      for (int k = 0; k < 2; k++)
         for (int w = 0; w < 16; w++)
            op(k, 1'b1, 32'(w * 4), $urandom, F3_W, 0, rd, er);

      op(0, 1'b1, 32'h10, 32'hDEAD_BEEF, F3_W, 0, rd, er);
      chk("sw_rdata", rd, 0); chk("sw_err", er, 0);
      op(0, 1'b0, 32'h10, 32'h0, F3_W, 0, rd, er);  chk("lw", rd, 32'hDEAD_BEEF);
      op(0, 1'b0, 32'h13, 32'h0, F3_B, 0, rd, er);  chk("lb", rd, 32'hFFFF_FFDE);
      op(0, 1'b0, 32'h13, 32'h0, F3_BU, 0, rd, er); chk("lbu", rd, 32'h0000_00DE);
      op(0, 1'b0, 32'h10, 32'h0, F3_H, 0, rd, er);  chk("lh", rd, 32'hFFFF_BEEF);
      op(0, 1'b0, 32'h12, 32'h0, F3_HU, 0, rd, er); chk("lhu", rd, 32'h0000_DEAD);
      op(0, 1'b1, 32'h11, 32'h0000_00AA, F3_B, 0, rd, er);
      op(0, 1'b0, 32'h10, 32'h0, F3_W, 0, rd, er);  chk("sb_lw", rd, 32'hDEAD_AAEF);

      op(0, 1'b0, 32'h12, 32'h0, F3_W, 0, rd, er);
      chk("mis_lw_err", er, 1); chk("mis_lw_rd", rd, 0);
      op(0, 1'b1, 32'h11, 32'h5555_5555, F3_H, 0, rd, er);
      chk("mis_sh_err", er, 1); chk("mis_sh_rd", rd, 0);
      op(0, 1'b0, 32'(DEPTH * 4), 32'h0, F3_W, 0, rd, er);
      chk("oor_err", er, 1); chk("oor_rd", rd, 0);
      op(0, 1'b0, 32'h10, 32'h0, 3'b011, 0, rd, er);
      chk("f3_err", er, 1); chk("f3_rd", rd, 0);
      op(0, 1'b0, 32'h10, 32'h0, F3_W, 0, rd, er);  chk("err_nowrite", rd, 32'hDEAD_AAEF);

      op(0, 1'b0, 32'h10, 32'h0, F3_W, 5, rd, er);  chk("bp_lw", rd, 32'hDEAD_AAEF);
      op(0, 1'b0, 32'h14, 32'h0, F3_W, 0, rd, er);  // injected store must not land

      op(0, 1'b1, 32'h20, 32'hA5A5_A5A5, F3_W, 0, rd, er);
      op(0, 1'b0, 32'h10, 32'h0, F3_W, 0, rd, er);
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_funct3 = F3_W;
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      chk("mid_wait_ready", req_ready[0], 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_req_ready", req_ready[0], 1);
      chk("mid_rst_rsp_valid", rsp_valid[0], 0);
      chk("mid_rst_rsp_rdata", rsp_rdata[0], 0);
      chk("mid_rst_rsp_err", rsp_err[0], 0);
      @(negedge clk);
      rst = 1'b0;
      op(0, 1'b0, 32'h20, 32'h0, F3_W, 0, rd, er);  chk("rst_no_commit", rd, 32'hA5A5_A5A5);

      op(1, 1'b1, 32'h20, 32'h1234_5678, F3_W, 0, rd, er);
      op(1, 1'b0, 32'h20, 32'h0, F3_W, 0, rd, er);  chk("wc0_lw", rd, 32'h1234_5678);
      op(1, 1'b0, 32'h20, 32'h0, F3_W, 3, rd, er);

      repeat (300) begin
         s = $urandom_range(0, 1);
         if ($urandom_range(0, 7) == 0) a = 32'(DEPTH * 4) + $urandom_range(0, 255);
         else                           a = $urandom_range(0, 63);
         hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
         op(s, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), hold, rd, er);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
